jtag_top: RTL and testbench
===========================

// Module: jtag_top
// PURPOSE
//  Self-contained IEEE 1149.1-style JTAG test block.
//  - An internal TMS sequencer drives a 16-state TAP controller, an instruction register and a boundary-scan data register.
//  - After reset it runs one IR scan, loading test_mode, then one DR scan.
//  - The DR scan captures parallel_inputs, shifts input_data in, collects the shifted-out bits on output_data and drives tdr_data_outs.
//  - It is the top of the automated JTAG test system.
// PARAMETERS
//  STATE_NUM        16  TAP state count; state register width is $clog2(STATE_NUM).
//  INSTRUCTION_NUM  4   instruction count; IR width IRW = $clog2(INSTRUCTION_NUM).
//  DATA_REG         5   boundary-scan register width; must equal DATA_SIZE.
//  DATA_SIZE        5   serial word length (number of Shift-DR cycles).
// PORTS
//  tclk             in   1          test clock; all state changes on the rising edge
//  trst_n           in   1          asynchronous active-low reset
//  test_mode        in   IRW        instruction shifted into the IR
//  input_data       in   DATA_SIZE  word shifted into the DR, LSB first
//  output_data      out  DATA_SIZE  bits shifted out of the DR, collected MSB-first
//  parallel_inputs  in   DATA_REG   pin values captured at Capture-DR
//  tdr_data_outs    out  DATA_REG   update register, latched at Update-DR
// BEHAVIOUR
//  - Reset: one clock (tclk); reset is asynchronous and active-low (trst_n).
//    - trst_n low: TAP goes to Test-Logic-Reset (TLR) and IR goes to BYPASS (11).
//    - Shift registers, output_data, tdr_data_outs and the sequencer step counter all clear to 0.
//    - Reset mid-scan aborts the scan; the sequence restarts from step 0 after release.
//  - TAP: the standard 16 states with standard TMS transitions.
//  - TMS sequence, one bit per tclk from release (TLR):
//    - 0,1,1,0,0 -> Shift-IR.
//    - (IRW-1) zeros, then 1 -> Exit1-IR.
//    - 1 (Update-IR), 0 (RTI), 1, 0, 0 -> Shift-DR.
//    - (DATA_SIZE-1) zeros, then 1 -> Exit1-DR.
//    - 1 (Update-DR), 0 (RTI).
//    - Afterwards TMS is held 0; the TAP parks in RTI until the next reset.
//    - The whole sequence completes in <=25 cycles.
//  - Capture-IR: IR shift register loads 2'b01.
//  - Shift-IR: shift right; TDI = test_mode[k] on the k-th shift (LSB first).
//  - Update-IR: IR <= IR shift register (equals test_mode).
//  - Decode: 00 EXTEST, 01 SAMPLE, 11 BYPASS; 10 is BYPASS unless JTAG_IDCODE_EN is defined.
//  - Capture-DR:
//    - EXTEST/SAMPLE: bsr <= parallel_inputs.
//    - BYPASS: 1-bit byp <= 0.
//    - output_data <= 0.
//  - Shift-DR, k-th cycle (k = 0..DATA_SIZE-1):
//    - tdi = input_data[k].
//    - tdo = bsr[0] (or byp), taken pre-shift.
//    - bsr <= {tdi, bsr[DATA_REG-1:1]}; byp <= tdi.
//    - output_data <= {output_data[DATA_SIZE-2:0], tdo}.
//  - Scan results:
//    - After DATA_SIZE shifts, bsr == input_data.
//    - output_data == bit-reverse of the captured value.
//  - Update-DR:
//    - EXTEST: tdr_data_outs <= bsr.
//    - All other instructions: tdr_data_outs holds its value.
//  - output_data and tdr_data_outs are registered and stable after the sequence ends.
//  - Inputs are sampled only in their use states; later input changes have no effect until the next reset.
// CONFIGURATION
//  JTAG_IDCODE_EN defined:
//    - IR code 10 selects a DATA_REG-bit IDCODE register.
//    - Its Capture-DR value is alternating bits with LSB = 1 (5'b10101 at default width).
//    - Shift behaviour is identical to bsr.
//    - Update-DR does not change tdr_data_outs.
//  JTAG_IDCODE_EN undefined: IR code 10 decodes as BYPASS.
// TESTING
//  1. EXTEST: reset 4 cycles, release; test_mode=00, parallel_inputs=10111, input_data=11001; wait 61 cycles
//     -> output_data=11101, tdr_data_outs=11001.
//  2. SAMPLE: test_mode=01, same data -> output_data=11101, tdr_data_outs=00000.
//  3. BYPASS: test_mode=11, input_data=11001 -> output_data=01001, tdr_data_outs=00000.
//  4. IDCODE: test_mode=10 with JTAG_IDCODE_EN -> output_data=10101, tdr_data_outs=00000.
//     Same stimulus without the macro -> BYPASS result 01001.
//  5. Reset mid-Shift-DR: EXTEST run, trst_n=0 at cycle 14
//     -> outputs 0 immediately; after release and 61 cycles the scenario 1 results are reached.
//  6. Input change after completion: change input_data/parallel_inputs after cycle 30
//     -> both outputs are unchanged.

Source files
------------

// File: rtl/jtag_top.sv
// Self-running JTAG test block: a fixed TMS sequencer walks the TAP through one IR scan and one
// DR scan. Optional IDCODE register on IR code 10 is enabled by defining JTAG_IDCODE_EN.
module jtag_top #(
  parameter int unsigned STATE_NUM       = 16,
  parameter int unsigned INSTRUCTION_NUM = 4,
  parameter int unsigned DATA_REG        = 5,
  parameter int unsigned DATA_SIZE       = 5,
  localparam int unsigned IRW            = $clog2(INSTRUCTION_NUM)
) (
  input  logic                 tclk,
  input  logic                 trst_n,
  input  logic [IRW-1:0]       test_mode,
  input  logic [DATA_SIZE-1:0] input_data,
  output logic [DATA_SIZE-1:0] output_data,
  input  logic [DATA_REG-1:0]  parallel_inputs,
  output logic [DATA_REG-1:0]  tdr_data_outs
);

  localparam int unsigned SW     = $clog2(STATE_NUM);
  localparam int unsigned IrIdxW = (IRW > 1) ? $clog2(IRW) : 1;
  localparam int unsigned DrIdxW = $clog2(DATA_SIZE);
  localparam int unsigned SeqLen = 12 + IRW + DATA_SIZE;
  localparam int unsigned StepW  = $clog2(SeqLen + 1);

  localparam logic [IRW-1:0] IrExtest = IRW'(0);
  localparam logic [IRW-1:0] IrSample = IRW'(1);

  typedef enum logic [SW-1:0] {
    StTlr, StRti, StSelDr, StCapDr, StShiftDr, StExit1Dr, StPauseDr, StExit2Dr,
    StUpdDr, StSelIr, StCapIr, StShiftIr, StExit1Ir, StPauseIr, StExit2Ir, StUpdIr
  } tap_e;

  tap_e              tap, tap_d;
  logic [StepW-1:0]  step;
  logic              tms;
  logic [IRW-1:0]    ir, ir_sr;
  logic [IrIdxW-1:0] ir_idx;
  logic [DrIdxW-1:0] dr_idx;
  logic [DATA_REG-1:0] bsr;
  logic              byp;
  logic              sel_ext, sel_bsr, tdo, tdi_ir, tdi_dr;

`ifdef JTAG_IDCODE_EN
  localparam logic [IRW-1:0] IrIdcode = IRW'(2);

  function automatic logic [DATA_REG-1:0] alt_ones();
    logic [DATA_REG-1:0] v;
    for (int i = 0; i < DATA_REG; i++) v[i] = (i % 2 == 0);
    return v;
  endfunction

  localparam logic [DATA_REG-1:0] IdcodeVal = alt_ones();

  logic [DATA_REG-1:0] idr;
  logic                sel_id;
  assign sel_id = (ir == IrIdcode);
`endif

  assign sel_ext = (ir == IrExtest);
  assign sel_bsr = sel_ext || (ir == IrSample);
  assign tdi_ir  = test_mode[ir_idx];
  assign tdi_dr  = input_data[dr_idx];

  always_comb begin
    tdo = byp;
    if (sel_bsr) tdo = bsr[0];
`ifdef JTAG_IDCODE_EN
    if (sel_id) tdo = idr[0];
`endif
  end

  // Positions of the ones in the TMS program: TLR -> Shift-IR -> Update-IR -> Shift-DR -> RTI.
  always_comb begin
    tms = 1'b0;
    if (step == StepW'(1) || step == StepW'(2) ||
        step == StepW'(IRW + 4) || step == StepW'(IRW + 5) || step == StepW'(IRW + 7) ||
        step == StepW'(IRW + DATA_SIZE + 9) || step == StepW'(IRW + DATA_SIZE + 10)) begin
      tms = 1'b1;
    end
  end

  always_comb begin
    tap_d = StTlr;
    unique case (tap)
      StTlr:     tap_d = tms ? StTlr     : StRti;
      StRti:     tap_d = tms ? StSelDr   : StRti;
      StSelDr:   tap_d = tms ? StSelIr   : StCapDr;
      StCapDr:   tap_d = tms ? StExit1Dr : StShiftDr;
      StShiftDr: tap_d = tms ? StExit1Dr : StShiftDr;
      StExit1Dr: tap_d = tms ? StUpdDr   : StPauseDr;
      StPauseDr: tap_d = tms ? StExit2Dr : StPauseDr;
      StExit2Dr: tap_d = tms ? StUpdDr   : StShiftDr;
      StUpdDr:   tap_d = tms ? StSelDr   : StRti;
      StSelIr:   tap_d = tms ? StTlr     : StCapIr;
      StCapIr:   tap_d = tms ? StExit1Ir : StShiftIr;
      StShiftIr: tap_d = tms ? StExit1Ir : StShiftIr;
      StExit1Ir: tap_d = tms ? StUpdIr   : StPauseIr;
      StPauseIr: tap_d = tms ? StExit2Ir : StPauseIr;
      StExit2Ir: tap_d = tms ? StUpdIr   : StShiftIr;
      StUpdIr:   tap_d = tms ? StSelDr   : StRti;
      default:   tap_d = StTlr;
    endcase
  end

  always_ff @(posedge tclk or negedge trst_n) begin
    if (!trst_n) begin
      tap           <= StTlr;
      step          <= '0;
      ir            <= '1;
      ir_sr         <= '0;
      ir_idx        <= '0;
      dr_idx        <= '0;
      bsr           <= '0;
      byp           <= 1'b0;
      output_data   <= '0;
      tdr_data_outs <= '0;
`ifdef JTAG_IDCODE_EN
      idr           <= '0;
`endif
    end else begin
      tap <= tap_d;
      if (step != StepW'(SeqLen)) step <= step + 1'b1;
      case (tap)
        StCapIr: begin
          ir_sr  <= IRW'(1);
          ir_idx <= '0;
        end
        StShiftIr: begin
          ir_sr  <= {tdi_ir, ir_sr[IRW-1:1]};
          ir_idx <= ir_idx + 1'b1;
        end
        StUpdIr: ir <= ir_sr;
        StCapDr: begin
          dr_idx      <= '0;
          output_data <= '0;
          if (sel_bsr) bsr <= parallel_inputs;
`ifdef JTAG_IDCODE_EN
          else if (sel_id) idr <= IdcodeVal;
`endif
          else byp <= 1'b0;
        end
        StShiftDr: begin
          dr_idx      <= dr_idx + 1'b1;
          output_data <= {output_data[DATA_SIZE-2:0], tdo};
          if (sel_bsr) bsr <= {tdi_dr, bsr[DATA_REG-1:1]};
`ifdef JTAG_IDCODE_EN
          else if (sel_id) idr <= {tdi_dr, idr[DATA_REG-1:1]};
`endif
          else byp <= tdi_dr;
        end
        StUpdDr: if (sel_ext) tdr_data_outs <= bsr;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_top.sv
// Bench for jtag_top: fixed vectors, hand-built reset/late-input sequences and random scans
// checked against a scan-level model.
module tb_jtag_top;

  logic       tclk   = 1'b0;
  logic       trst_n = 1'b1;
  logic [1:0] test_mode;
  logic [4:0] input_data, parallel_inputs, output_data, tdr_data_outs;

  int checks = 0;
  int errors = 0;

  jtag_top dut (
    .tclk            (tclk),
    .trst_n          (trst_n),
    .test_mode       (test_mode),
    .input_data      (input_data),
    .output_data     (output_data),
    .parallel_inputs (parallel_inputs),
    .tdr_data_outs   (tdr_data_outs)
  );

  always #5 tclk = ~tclk;

  typedef struct {
    logic [1:0] tm;
    logic [4:0] pi;
    logic [4:0] din;
    logic [4:0] exp_out;
    logic [4:0] exp_tdr;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Scan-level view: the chain emits its captured contents (or, for bypass, a 0 then TDI
  // delayed by one), first bit out lands in the MSB; only EXTEST drives the pins.
  function automatic void model(input logic [1:0] tm, input logic [4:0] pi, input logic [4:0] din,
                                output logic [4:0] out, output logic [4:0] tdr);
    logic [4:0] cap;
    logic       is_byp;
    is_byp = 1'b0;
    cap    = pi;
    if (tm == 2'b10) begin
`ifdef JTAG_IDCODE_EN
      cap = 5'b10101;
`else
      is_byp = 1'b1;
`endif
    end else if (tm == 2'b11) begin
      is_byp = 1'b1;
    end
    for (int k = 0; k < 5; k++) begin
      if (!is_byp)     out[4-k] = cap[k];
      else if (k == 0) out[4-k] = 1'b0;
      else             out[4-k] = din[k-1];
    end
    tdr = (tm == 2'b00) ? din : 5'b00000;
  endfunction

  // Reset (checked asynchronously), load inputs, release, then run wait_cycles clocks.
  task automatic run_scan(input logic [1:0] tm, input logic [4:0] pi, input logic [4:0] din,
                          input int wait_cycles);
    @(negedge tclk);
    #1 trst_n = 1'b0;
    #1;
    check("reset output_data", output_data, 5'b00000);
    check("reset tdr_data_outs", tdr_data_outs, 5'b00000);
    test_mode       = tm;
    parallel_inputs = pi;
    input_data      = din;
    repeat (4) @(negedge tclk);
    trst_n = 1'b1;
    repeat (wait_cycles) @(negedge tclk);
  endtask

  initial begin
    logic [4:0] m_out, m_tdr;

    test_mode       = 2'b00;
    input_data      = 5'b00000;
    parallel_inputs = 5'b00000;

    vecs[0] = '{2'b00, 5'b10111, 5'b11001, 5'b11101, 5'b11001};
    vecs[1] = '{2'b01, 5'b10111, 5'b11001, 5'b11101, 5'b00000};
    vecs[2] = '{2'b11, 5'b10111, 5'b11001, 5'b01001, 5'b00000};
`ifdef JTAG_IDCODE_EN
    vecs[3] = '{2'b10, 5'b10111, 5'b11001, 5'b10101, 5'b00000};
`else
    vecs[3] = '{2'b10, 5'b10111, 5'b11001, 5'b01001, 5'b00000};
`endif
    vecs[4] = '{2'b00, 5'b00000, 5'b11111, 5'b00000, 5'b11111};

    for (int i = 0; i < 5; i++) begin
      run_scan(vecs[i].tm, vecs[i].pi, vecs[i].din, 61);
      check($sformatf("vec%0d output_data", i), output_data, vecs[i].exp_out);
      check($sformatf("vec%0d tdr_data_outs", i), tdr_data_outs, vecs[i].exp_tdr);
    end

    // Completed EXTEST, then reset mid Shift-DR after three shifts.
    run_scan(2'b00, 5'b10111, 5'b11001, 61);
    check("pre-abort tdr_data_outs", tdr_data_outs, 5'b11001);
    run_scan(2'b00, 5'b10111, 5'b11001, 15);
    check("mid-shift output_data", output_data, 5'b00111);
    #1 trst_n = 1'b0;
    #1;
    check("abort output_data", output_data, 5'b00000);
    check("abort tdr_data_outs", tdr_data_outs, 5'b00000);
    repeat (2) @(negedge tclk);
    trst_n = 1'b1;
    repeat (61) @(negedge tclk);
    check("restart output_data", output_data, 5'b11101);
    check("restart tdr_data_outs", tdr_data_outs, 5'b11001);

    // Sequence done within 25 clocks; later input changes are ignored.
    run_scan(2'b00, 5'b10111, 5'b11001, 25);
    check("25cyc output_data", output_data, 5'b11101);
    check("25cyc tdr_data_outs", tdr_data_outs, 5'b11001);
    input_data      = 5'b00110;
    parallel_inputs = 5'b01000;
    test_mode       = 2'b11;
    repeat (36) @(negedge tclk);
    check("late output_data", output_data, 5'b11101);
    check("late tdr_data_outs", tdr_data_outs, 5'b11001);

    for (int i = 0; i < 12; i++) begin
      logic [1:0] tm;
      logic [4:0] pi, din;
      tm  = 2'($urandom_range(0, 3));
      pi  = 5'($urandom);
      din = 5'($urandom);
      model(tm, pi, din, m_out, m_tdr);
      run_scan(tm, pi, din, 61);
      check($sformatf("rand%0d output_data tm=%b", i, tm), output_data, m_out);
      check($sformatf("rand%0d tdr_data_outs tm=%b", i, tm), tdr_data_outs, m_tdr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
